crg_batch_sched: RTL and testbench

Batch scheduler for the correlated-random generator's pipelined AES core. On `start` it issues `batch_len` consecutive counter blocks (`ctr_base + i`) into the AES pipeline, one per cycle. It writes each returned ciphertext into the 256-entry result RAM at index `i`. It also arbitrates the single RAM port between pipeline write-back and host (UART) read-out, so the host can read results during and after a batch.

---
 rtl/crg_batch_sched.sv | 154 +++++++++++++++
 tb/tb_crg_batch_sched.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crg_batch_sched.sv
// rtl/crg_batch_sched.sv - AES counter-block batch scheduler with result-RAM port arbitration
// Optional abort support is compiled in when CRG_SCHED_ABORT_EN is defined.
module crg_batch_sched #(
    parameter int AES_LAT = 10,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CRG_SCHED_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    input  logic              start,
    input  logic [ADDR_W:0]   batch_len,
    input  logic [127:0]      ctr_base,
    output logic [127:0]      aes_din,
    output logic              aes_drdy,
    input  logic              aes_dvld,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // A zero-latency core would return each block while wr_cnt == iss_cnt,
    // which the write-back guard treats as spurious.
    if (AES_LAT < 1) begin : g_bad_lat
        $error("crg_batch_sched: AES_LAT must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [127:0]      base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   iss_cnt;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   wr_cnt_nxt;
    logic              wb_ok;
    logic              accept;
    logic              abort_req;

`ifdef CRG_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept     = (state == S_IDLE) && start;
    assign wb_ok      = aes_dvld && (state == S_ISSUE || state == S_DRAIN) && (wr_cnt != iss_cnt);
    assign wr_cnt_nxt = wr_cnt + {{ADDR_W{1'b0}}, wb_ok};

    // Write-back owns the RAM port whenever a result arrives; the host waits.
    assign ram_we   = wb_ok;
    assign rd_ack   = rd_req & ~ram_we;
    assign ram_addr = ram_we ? wr_cnt[ADDR_W-1:0] : (rd_ack ? rd_addr : '0);

    assign busy = (state == S_ISSUE) || (state == S_DRAIN);
    assign done = (state == S_FIN);

    always_comb begin
        state_nxt = state;
        aes_drdy  = 1'b0;
        aes_din   = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (batch_len == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort_req) begin
                    state_nxt = S_DRAIN;
                end else begin
                    aes_drdy = 1'b1;
                    aes_din  = base_q + {{(127 - ADDR_W){1'b0}}, iss_cnt};
                    if (iss_cnt == len_q - CNT_ONE) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (wr_cnt_nxt == len_q) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            iss_cnt <= '0;
            wr_cnt  <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base_q  <= ctr_base;
                len_q   <= batch_len;
                iss_cnt <= '0;
                wr_cnt  <= '0;
            end else begin
                if (aes_drdy) begin
                    iss_cnt <= iss_cnt + CNT_ONE;
                end
                if (wb_ok) begin
                    wr_cnt <= wr_cnt_nxt;
                end
                // The pipeline cannot be flushed, so drain only what was issued.
                if (state == S_ISSUE && abort_req) begin
                    len_q <= iss_cnt;
                end
            end
            err <= (err & ~accept) | (aes_dvld & ~wb_ok);
        end
    end

`ifdef CRG_SCHED_ABORT_EN
    logic abt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abt_q   <= 1'b0;
            aborted <= 1'b0;
        end else if (accept) begin
            abt_q   <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (state == S_ISSUE && abort) begin
                abt_q <= 1'b1;
            end
            if (state_nxt == S_FIN && abt_q) begin
                aborted <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crg_batch_sched.sv
// tb/tb_crg_batch_sched.sv - randomized self-checking bench for crg_batch_sched
module tb_crg_batch_sched;
    localparam int L  = 10;
    localparam int AW = 8;
    localparam int NR = 1 << AW;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [AW:0]   batch_len = '0;
    logic [127:0]  ctr_base  = '0;
    logic [127:0]  aes_din;
    logic          aes_drdy;
    logic          aes_dvld;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          rd_req    = 1'b0;
    logic [AW-1:0] rd_addr   = '0;
    logic          rd_ack;
    logic          busy;
    logic          done;
    logic          err;
    logic          abort_now;
`ifdef CRG_SCHED_ABORT_EN
    logic          abort     = 1'b0;
    logic          aborted;
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    crg_batch_sched #(.AES_LAT(L), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CRG_SCHED_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .start     (start),
        .batch_len (batch_len),
        .ctr_base  (ctr_base),
        .aes_din   (aes_din),
        .aes_drdy  (aes_drdy),
        .aes_dvld  (aes_dvld),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    function automatic logic [127:0] aes_f(input logic [127:0] x);
        return {x[63:0], x[127:64]} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    // AES core stand-in: fixed-latency pipeline, not affected by the scheduler reset
    logic         pv [L];
    logic [127:0] pd [L];
    logic         spur = 1'b0;
    assign aes_dvld = pv[L-1] | spur;

    always @(posedge clk) begin
        pv[0] <= aes_drdy;
        pd[0] <= aes_f(aes_din);
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    logic [127:0] ram [NR];
    logic [127:0] exp_ram [NR];
    logic         rd_vld  = 1'b0;
    logic [127:0] rd_dout = '0;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= pd[L-1];
        rd_vld  <= rd_ack;
        rd_dout <= ram[ram_addr];
    end

    // Reference model: one batch described by its start cycle, length and base
    bit           m_act  = 1'b0;
    bit           m_ab   = 1'b0;
    bit           m_err  = 1'b0;
    int           m_t    = 0;
    int           m_n    = 0;
    logic [127:0] m_base = '0;
    bit           exp_rdv = 1'b0;
    logic [127:0] exp_rd  = '0;

    function automatic int m_end();
        return (m_n == 0) ? m_t + 1 : m_t + m_n + L + 1;
    endfunction
    function automatic bit e_issue(input int c);
        return m_act && c > m_t && c <= m_t + m_n;
    endfunction
    function automatic bit e_we(input int c);
        return m_act && c > m_t + L && c <= m_t + m_n + L;
    endfunction
    function automatic bit e_busy(input int c);
        return m_act && m_n > 0 && c > m_t && c <= m_t + m_n + L;
    endfunction
    function automatic bit e_done(input int c);
        return m_act && c == m_end();
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual %0d required %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_act   = 1'b0;
            m_ab    = 1'b0;
            m_err   = 1'b0;
            exp_rdv = 1'b0;
        end else begin
            bit we_e;
            bit set_e;
            int k;
            we_e    = e_we(cyc);
            exp_rdv = rd_req && !we_e;
            if (exp_rdv) exp_rd = exp_ram[rd_addr];
            if (we_e) begin
                k = cyc - m_t - 1 - L;
                exp_ram[k] = aes_f(m_base + 128'(k));
            end
            set_e = aes_dvld && !we_e;
            if (abort_now && e_issue(cyc)) begin
                m_n  = cyc - m_t - 1;
                m_ab = 1'b1;
            end
            if (start && (!m_act || cyc > m_end())) begin
                m_act  = 1'b1;
                m_t    = cyc;
                m_n    = int'(batch_len);
                m_base = ctr_base;
                m_ab   = 1'b0;
                m_err  = set_e;
            end else begin
                m_err = m_err | set_e;
            end
        end
        cyc++;
    end

    int           n_drdy     = 0;
    int           n_we       = 0;
    int           done_cyc   = -1;
    int           first_ack  = -1;
    bit           done_seen  = 1'b0;
    bit           ack_seen   = 1'b0;
    bit           rnd_rd     = 1'b0;
    logic [127:0] din_q [$];

    always @(negedge clk) begin
        if (rst_n) begin
            bit d_e;
            bit w_e;
            bit a_e;
            d_e = e_issue(cyc) && !abort_now;
            w_e = e_we(cyc);
            a_e = rd_req && !w_e;
            chk("aes_drdy", 128'(aes_drdy), 128'(d_e));
            if (d_e) chk("aes_din", aes_din, m_base + 128'(cyc - m_t - 1));
            chk("ram_we", 128'(ram_we), 128'(w_e));
            chk("rd_ack", 128'(rd_ack), 128'(a_e));
            if (w_e) chk("ram_addr_wr", 128'(ram_addr), 128'(cyc - m_t - 1 - L));
            else if (a_e) chk("ram_addr_rd", 128'(ram_addr), 128'(rd_addr));
            chk("busy", 128'(busy), 128'(e_busy(cyc)));
            chk("done", 128'(done), 128'(e_done(cyc)));
            chk("err", 128'(err), 128'(m_err));
            chk("rd_vld", 128'(rd_vld), 128'(exp_rdv));
            if (exp_rdv) chk("rd_data", rd_dout, exp_rd);
`ifdef CRG_SCHED_ABORT_EN
            chk("aborted", 128'(aborted), 128'(m_ab && cyc >= m_end()));
`endif
            if (aes_drdy) begin
                n_drdy++;
                din_q.push_back(aes_din);
            end
            if (ram_we) n_we++;
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (rd_ack && first_ack < 0) first_ack = cyc;
        end
        ack_seen = rd_ack;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (ack_seen) rd_req = 1'b0;
        if (rnd_rd && !rd_req && $urandom_range(0, 3) == 0) begin
            rd_req  = 1'b1;
            rd_addr = AW'($urandom);
        end
    endtask

    task automatic kick(input logic [127:0] b, input int n, output int t);
        ctr_base  = b;
        batch_len = n[AW:0];
        start     = 1'b1;
        t         = cyc;
        n_drdy    = 0;
        n_we      = 0;
        din_q.delete();
        done_seen = 1'b0;
        first_ack = -1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int i;
        i = 0;
        while (!done_seen && i < bound) begin
            step();
            i++;
        end
        chk_int("done_seen", int'(done_seen), 1);
    endtask

    task automatic ram_check(input string name, input logic [127:0] b, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (ram[i] !== aes_f(b + 128'(i))) bad++;
        end
        chk_int(name, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int t;
        int n;
        logic [127:0] b;
        for (int i = 0; i < L; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        for (int i = 0; i < NR; i++) begin
            ram[i]     = '0;
            exp_ram[i] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_drdy", 128'(aes_drdy), 128'(0));
        chk("rst_din", aes_din, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_we", 128'(ram_we), 128'(0));
        rst_n = 1'b1;
        repeat (2) step();

        // Full batch with one uncontended and one contended host read
        kick(128'd0, 256, t);
        while (cyc < t + 5) step();
        rd_addr = 8'd5;
        rd_req  = 1'b1;
        while (cyc < t + 20) step();
        chk_int("rd_first_ack", first_ack - t, 5);
        first_ack = -1;
        rd_req    = 1'b1;
        wait_done(400);
        chk_int("rd_contended_ack", first_ack - t, 267);
        chk_int("full_done_lat", done_cyc - t, 267);
        chk_int("full_drdy", n_drdy, 256);
        chk_int("full_we", n_we, 256);
        chk_int("full_din_cnt", din_q.size(), 256);
        if (din_q.size() == 256) begin
            chk("full_din_first", din_q[0], 128'd0);
            chk("full_din_last", din_q[255], 128'd255);
        end
        chk("full_err", 128'(err), 128'(0));
        ram_check("full_ram", 128'd0, 256);
        step();

        // Counter wrap
        b = '1;
        b = b - 128'd1;
        kick(b, 4, t);
        wait_done(50);
        chk_int("wrap_cnt", din_q.size(), 4);
        if (din_q.size() == 4) begin
            chk("wrap_din0", din_q[0], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
            chk("wrap_din1", din_q[1], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
            chk("wrap_din2", din_q[2], 128'd0);
            chk("wrap_din3", din_q[3], 128'd1);
        end
        ram_check("wrap_ram", b, 4);

        // Degenerate batch
        kick(128'd7, 0, t);
        wait_done(10);
        chk_int("zero_done_lat", done_cyc - t, 1);
        chk_int("zero_drdy", n_drdy, 0);

        // Start during ISSUE is ignored
        kick(128'h0ABC_0000, 30, t);
        step();
        step();
        ctr_base  = 128'h5555_0000;
        batch_len = 9'd5;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_done(100);
        chk_int("busy_start_drdy", n_drdy, 30);
        chk_int("busy_start_lat", done_cyc - t, 41);
        ram_check("busy_start_ram", 128'h0ABC_0000, 30);

        // Reset mid-batch, then in-flight results arrive as spurious valids
        kick(128'h1000, 20, t);
        while (cyc < t + 3) step();
        rst_n = 1'b0;
        #1;
        chk("arst_drdy", 128'(aes_drdy), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_din", aes_din, 128'(0));
        step();
        rst_n = 1'b1;
        n_we  = 0;
        repeat (L + 4) step();
        chk_int("spur_no_we", n_we, 0);
        chk("spur_err", 128'(err), 128'(1));
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        kick(128'd5, 3, t);
        chk("start_clr_err", 128'(err), 128'(0));
        wait_done(50);

`ifdef CRG_SCHED_ABORT_EN
        kick(128'h77, 100, t);
        while (cyc < t + 21) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done(100);
        chk_int("abort_drdy", n_drdy, 20);
        chk_int("abort_we", n_we, 20);
        chk_int("abort_done_lat", done_cyc - t, 20 + L + 1);
        chk("abort_flag", 128'(aborted), 128'(1));
        ram_check("abort_ram", 128'h77, 20);
`endif

        // Randomized batches with random host reads and idle spurious valids
        rnd_rd = 1'b1;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 40);
            b = {$urandom, $urandom, $urandom, $urandom};
            kick(b, n, t);
            wait_done(n + L + 20);
            chk_int("rnd_drdy", n_drdy, n);
            chk_int("rnd_lat", done_cyc - t, n + L + 1);
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 1) == 1) begin
                spur = 1'b1;
                step();
                spur = 1'b0;
                step();
            end
        end
        rnd_rd = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
